// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: fetch/exec/write-back sequencer over an 8-entry regfile and a bitwise logic unit
module logic_op_sequencer #(
  parameter int w = 16,
  parameter int NREG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [2:0]   src1,
  input  logic [2:0]   src2,
  input  logic [2:0]   dst,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [w-1:0] wr_data,
  input  logic [2:0]   rd_addr,
  output logic [w-1:0] rd_data,
  output logic [w-1:0] numar1,
  output logic [w-1:0] numar2,
  output logic [w-1:0] O,
  output logic         busy,
  output logic         done,
  output logic         wr_rej
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
  state_t state, nxt;
  logic [1:0] op_q;
  logic [2:0] s1_q, s2_q, d_q;
  logic [w-1:0] rf [NREG];
  logic [w-1:0] res;
  assign rd_data = rf[rd_addr];
  // next state, busy flag and the logic unit result
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? FETCH : IDLE;
      FETCH:   nxt = EXEC;
      EXEC:    nxt = WB;
      default: nxt = IDLE;
    endcase
    busy = state != IDLE;
    res = op_q == 2'd0 ? numar1 | numar2 :
          op_q == 2'd1 ? numar1 & numar2 :
          op_q == 2'd2 ? numar1 ^ numar2 : ~numar1;
  end
  // state, captured command, operand/result latches and handshake pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      d_q <= '0;
      numar1 <= '0;
      numar2 <= '0;
      O <= '0;
      done <= 1'b0;
      wr_rej <= 1'b0;
    end else begin
      state <= nxt;
      done <= state == WB;
      wr_rej <= wr_en && state != IDLE;
      if (state == IDLE && start) {op_q, s1_q, s2_q, d_q} <= {op, src1, src2, dst};
      if (state == FETCH) begin
        numar1 <= rf[s1_q];
        numar2 <= rf[s2_q];
      end
      if (state == EXEC) O <= res;
    end
  end
  // regfile: external loads only while idle, write-back in WB never collides with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (state == IDLE && wr_en) rf[wr_addr] <= wr_data;
      if (state == WB) rf[d_q] <= O;
    end
  end
endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Multi-cycle sequencer that owns an 8-entry register file and is the producer and consumer on both sides of the bitwise logic unit's word interface.
- Fetches two operands, applies a bitwise operation (OR, AND, XOR, NOT), captures the result word and writes it back to a destination register.
- Sits between instruction decode and the combinational logic datapath of the processor simulation.
- Handshake is start/busy/done.

Parameters:
- w, 16, word width in bits.
- NREG, 8, number of registers; address width is 3 bits, fixed.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request an operation; sampled only in IDLE.
- op  input  2  00 OR, 01 AND, 10 XOR, 11 NOT (of operand 1); sampled with start.
- src1  input  3  operand 1 register address; sampled with start.
- src2  input  3  operand 2 register address; sampled with start.
- dst  input  3  destination register address; sampled with start.
- wr_en  input  1  external register load enable.
- wr_addr  input  3  external load address.
- wr_data  input  w  external load data.
- rd_addr  input  3  observation read address.
- rd_data  output  w  combinational read of regfile[rd_addr].
- numar1  output  w  latched operand 1.
- numar2  output  w  latched operand 2.
- O  output  w  latched result word.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after write-back.
- wr_rej  output  1  one-cycle pulse when an external write is dropped.

Behaviour:
- Reset: asynchronous on rst_n low, active-low; no synchronous reset.
  - All registers clear to 0: numar1, numar2, O, regfile.
  - State goes to IDLE; busy=0, done=0, wr_rej=0.
- FSM states: IDLE, FETCH, EXEC, WB.
  - IDLE: start=1 at edge k latches op/src1/src2/dst; next state FETCH.
  - FETCH: at edge k+1, numar1<=reg[src1] and numar2<=reg[src2]; next EXEC.
  - EXEC: at edge k+2, O<=f(op,numar1,numar2); next WB. NOT ignores numar2.
  - WB: at edge k+3, reg[dst]<=O and done<=1; next IDLE.
- Latency: done is high in the cycle after edge k+3. A new start is accepted in that same cycle, giving 4-cycle throughput.
- busy is combinational from state: high in FETCH, EXEC and WB.
- start while busy is ignored; no queuing.
- op/src/dst are captured at start. Input changes after acceptance have no effect.
- Operations are bitwise per bit, no carries; the result width is exactly w.
- External write when busy=0 takes effect at the next edge.
  - Same-edge start plus wr_en in IDLE: the write lands at edge k, so FETCH at edge k+1 reads the new value.
- External write when busy=1 is dropped, regfile is unchanged, and wr_rej pulses for one cycle.
- Address aliasing is legal (src1==src2, dst==src1/src2). Write-back uses the O captured in EXEC.
- rd_data reflects writes from the following cycle onward; no bypass.
- Reset mid-operation aborts the operation: no write-back, no done.
- numar1, numar2 and O hold their values between operations.

Test Plan:
- Load via wr_en: reg1=16'hFB01, reg2=16'h3B61. Start op=00, src1=1, src2=2, dst=3 -> busy for 3 cycles, done pulses once at k+3, O=16'hFB61, reg3 reads 16'hFB61.
- Same operands with op=01/10/11, dst=4/5/6 -> reg4=16'h3B01, reg5=16'hC060, reg6=16'h04FE.
- Start held high for 10 cycles -> exactly one accept per 4 cycles. During busy, wr_en to reg1 gives wr_rej=1 and reg1 unchanged.
- Same-cycle start and wr_en(addr1, 16'h00FF) in IDLE, op=00, src1=1, src2=1, dst=1 -> reg1=16'h00FF, done once.
- rst_n low during EXEC -> busy=0, done never asserts, dst register stays 0, all outputs 0.
- Back-to-back ops chaining dst as the next src: reg1 OR reg2 -> reg3, then reg3 XOR reg1 -> reg7 -> reg7=16'h0060.
